// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked sequential ALU: opcodes, FSM states and flag positions.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } alu_state_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_NEG   = 3;
    localparam int unsigned NUM_FLAGS  = 4;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, word_length steps.
module alu_shift_add_mul #(
    parameter int unsigned word_length = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic [word_length-1:0]     i_a,
    input  logic [word_length-1:0]     i_b,
    output logic                       o_done,
    output logic [2*word_length-1:0]   o_product
);

    localparam int unsigned CntW = $clog2(word_length + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(word_length - 1);

    logic [2*word_length-1:0] r_mcand;
    logic [word_length-1:0]   r_mplier;
    logic [2*word_length-1:0] r_acc;
    logic [CntW-1:0]          r_count;
    logic                     r_active;
    logic [2*word_length-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // The final step's sum is presented combinationally so the caller can register it
    // on the same edge that performs that step.
    assign o_done    = r_active && (r_count == LastStep);
    assign o_product = w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{word_length{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CntW'(1);
            if (r_count == LastStep) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with eight ops and full flag set; results held on the output until consumed.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned word_length = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [word_length-1:0] A,
    input  logic [word_length-1:0] B,
    input  logic [2:0]             ALU_control,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [word_length-1:0] C,
    output logic [word_length-1:0] C_hi,
    output logic                   zero_flag,
    output logic                   carry_flag,
    output logic                   overflow_flag,
    output logic                   negative_flag,
    output logic                   busy
);

    localparam int unsigned ShW = $clog2(word_length);

    alu_state_e                 r_state;
    alu_state_e                 w_state_next;
    logic                       w_accept;
    logic                       w_mul_start;
    logic                       w_mul_done;
    logic [2*word_length-1:0]   w_product;
    logic [word_length:0]       w_sum;
    logic [word_length:0]       w_diff;
    logic [ShW-1:0]             w_shamt;
    logic                       w_shift_over;
    logic [word_length-1:0]     w_res;
    logic                       w_carry;
    logic                       w_ovf;
    logic [word_length-1:0]     r_c;
    logic [word_length-1:0]     r_c_hi;
    logic [NUM_FLAGS-1:0]       r_flags;

    assign w_accept    = (r_state == StIdle) && in_valid;
    assign w_mul_start = w_accept && (ALU_control == ALU_MUL);

    // The multiplier captures its own operands at acceptance, so later input changes are ignored.
    alu_shift_add_mul #(
        .word_length(word_length)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_a       (A),
        .i_b       (B),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_state_next = (ALU_control == ALU_MUL) ? StMul : StDone;
                end
            end
            StMul: begin
                if (w_mul_done) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            StIdle:  in_ready  = 1'b1;
            StMul:   busy      = 1'b1;
            StDone:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_comb begin
        w_sum        = {1'b0, A} + {1'b0, B};
        w_diff       = {1'b0, A} - {1'b0, B};
        w_shamt      = B[ShW-1:0];
        w_shift_over = ({1'b0, w_shamt} >= (ShW + 1)'(word_length));
        w_res        = '0;
        w_carry      = 1'b0;
        w_ovf        = 1'b0;
        case (ALU_control)
            ALU_ADD: begin
                w_res   = w_sum[word_length-1:0];
                w_carry = w_sum[word_length];
                w_ovf   = (A[word_length-1] == B[word_length-1]) &&
                          (w_sum[word_length-1] != A[word_length-1]);
            end
            ALU_SUB: begin
                w_res   = w_diff[word_length-1:0];
                w_carry = w_diff[word_length];
                w_ovf   = (A[word_length-1] != B[word_length-1]) &&
                          (w_diff[word_length-1] != A[word_length-1]);
            end
            ALU_AND: w_res = A & B;
            ALU_OR:  w_res = A | B;
            ALU_XOR: w_res = A ^ B;
            ALU_SLL: w_res = w_shift_over ? '0 : (A << w_shamt);
            ALU_SRL: w_res = w_shift_over ? '0 : (A >> w_shamt);
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c     <= '0;
            r_c_hi  <= '0;
            r_flags <= '0;
        end else if (w_accept && (ALU_control != ALU_MUL)) begin
            r_c                <= w_res;
            r_c_hi             <= '0;
            r_flags[FLAG_ZERO]  <= (w_res == '0);
            r_flags[FLAG_CARRY] <= w_carry;
            r_flags[FLAG_OVF]   <= w_ovf;
            r_flags[FLAG_NEG]   <= w_res[word_length-1];
        end else if ((r_state == StMul) && w_mul_done) begin
            r_c                <= w_product[word_length-1:0];
            r_c_hi             <= w_product[2*word_length-1:word_length];
            r_flags[FLAG_ZERO]  <= (w_product == '0);
            r_flags[FLAG_CARRY] <= 1'b0;
            r_flags[FLAG_OVF]   <= 1'b0;
            r_flags[FLAG_NEG]   <= w_product[2*word_length-1];
        end
    end

    assign C             = r_c;
    assign C_hi          = r_c_hi;
    assign zero_flag     = r_flags[FLAG_ZERO];
    assign carry_flag    = r_flags[FLAG_CARRY];
    assign overflow_flag = r_flags[FLAG_OVF];
    assign negative_flag = r_flags[FLAG_NEG];

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit at word_length=8: expected results queued at issue.
module tb_alu_seq_unit;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] c;
        logic [W-1:0] c_hi;
        logic         z;
        logic         cy;
        logic         ov;
        logic         n;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   ALU_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] C;
    logic [W-1:0] C_hi;
    logic         zero_flag;
    logic         carry_flag;
    logic         overflow_flag;
    logic         negative_flag;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    alu_seq_unit #(
        .word_length(W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .A             (A),
        .B             (B),
        .ALU_control   (ALU_control),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .C             (C),
        .C_hi          (C_hi),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .negative_flag (negative_flag),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        res_t       r;
        logic [W:0] s;
        logic [2*W-1:0] p;
        int         sa, sb, sr;
        r  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            ALU_ADD: begin
                s    = {1'b0, a} + {1'b0, b};
                r.c  = s[W-1:0];
                r.cy = s[W];
                sr   = sa + sb;
                r.ov = (sr > 127) || (sr < -128);
            end
            ALU_SUB: begin
                r.c  = a - b;
                r.cy = (a < b);
                sr   = sa - sb;
                r.ov = (sr > 127) || (sr < -128);
            end
            ALU_AND: r.c = a & b;
            ALU_OR:  r.c = a | b;
            ALU_XOR: r.c = a ^ b;
            ALU_SLL: r.c = a << b[2:0];
            ALU_SRL: r.c = a >> b[2:0];
            default: begin
                p      = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r.c    = p[W-1:0];
                r.c_hi = p[2*W-1:W];
            end
        endcase
        r.z = ({r.c_hi, r.c} == '0);
        r.n = (op == ALU_MUL) ? r.c_hi[W-1] : r.c[W-1];
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        return (op == ALU_MUL) ? W : 0;
    endfunction

    function automatic res_t sample_out();
        return {C, C_hi, zero_flag, carry_flag, overflow_flag, negative_flag};
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic acc);
        ALU_control = op;
        A           = a;
        B           = b;
        in_valid    = 1'b1;
        acc         = in_ready;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        A           = W'($urandom);
        B           = W'($urandom);
        ALU_control = 3'($urandom);
    endtask

    // lat = edges after the accepting edge until out_valid; -1 if the bound expires.
    task automatic wait_out(output int lat, output int bc, output res_t got);
        lat = 0;
        bc  = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        got = sample_out();
    endtask

    task automatic run_one(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic acc, output int lat, output int bc, output res_t got);
        send(op, a, b, acc);
        wait_out(lat, bc, got);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        ALU_control = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({out_valid, busy, in_ready, sample_out()} !== {1'b0, 1'b0, 1'b1, 20'h0}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b busy=%b ready=%b out=%h, required 0 0 1 00000",
                     out_valid, busy, in_ready, sample_out());
        end
    endtask

    task automatic test_table(input string name, input int n, input logic [2:0] ops[8],
                              input logic [W-1:0] as[8], input logic [W-1:0] bs[8],
                              input res_t exps[8], input logic use_model);
        logic acc;
        int   lat, bc;
        res_t got, exp;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(use_model ? model(ops[i], as[i], bs[i]) : exps[i]);
            run_one(ops[i], as[i], bs[i], acc, lat, bc, got);
            exp = exp_q.pop_front();
            checks++;
            if (acc !== 1'b1 || lat != exp_lat(ops[i]) || bc != exp_lat(ops[i])) begin
                errors++;
                $display("FAIL %s_timing[%0d]: accepted=%b latency=%0d busy=%0d, required 1 %0d %0d",
                         name, i, acc, lat, bc, exp_lat(ops[i]), exp_lat(ops[i]));
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_result[%0d]: got %h, required %h", name, i, got, exp);
            end
            consume();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_release[%0d]: valid=%b ready=%b, required 0 1",
                         name, i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_add_sub();
        logic [2:0]   ops[8] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_ADD, 0, 0, 0, 0};
        logic [W-1:0] as[8]  = '{8'hFF, 8'h80, 8'h03, 8'h7F, 0, 0, 0, 0};
        logic [W-1:0] bs[8]  = '{8'h01, 8'h01, 8'h05, 8'h01, 0, 0, 0, 0};
        res_t         ex[8]  = '{{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
                                 {8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0},
                                 {8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1},
                                 {8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
                                 '0, '0, '0, '0};
        test_table("addsub", 4, ops, as, bs, ex, 1'b0);
    endtask

    task automatic test_logic_shift();
        logic [2:0]   ops[8] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SLL,
                                 ALU_SRL};
        logic [W-1:0] as[8]  = '{8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h81, 8'h80, 8'hA5, 8'hA5};
        logic [W-1:0] bs[8]  = '{8'h3C, 8'h3C, 8'h3C, 8'hF0, 8'h09, 8'h07, 8'h00, 8'h04};
        res_t         ex[8]  = '{default: '0};
        test_table("logshift", 8, ops, as, bs, ex, 1'b1);
        // Fixed-value cross-check of the shift vectors independent of the model.
        exp_q.push_back({8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) begin
            logic acc;
            int   lat, bc;
            res_t got, exp;
            run_one((i == 0) ? ALU_SLL : ALU_SRL, (i == 0) ? 8'h81 : 8'h80,
                    (i == 0) ? 8'h09 : 8'h07, acc, lat, bc, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || lat != 0) begin
                errors++;
                $display("FAIL shift_vec[%0d]: got %h lat %0d, required %h lat 0", i, got, lat, exp);
            end
            consume();
        end
    endtask

    task automatic test_mul();
        logic [2:0]   ops[8] = '{ALU_MUL, ALU_MUL, ALU_MUL, ALU_MUL, 0, 0, 0, 0};
        logic [W-1:0] as[8]  = '{8'hFF, 8'h00, 8'h0C, 8'h01, 0, 0, 0, 0};
        logic [W-1:0] bs[8]  = '{8'hFF, 8'h5A, 8'h0D, 8'h80, 0, 0, 0, 0};
        res_t         ex[8]  = '{{8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1},
                                 {8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0},
                                 {8'h9C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0},
                                 {8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0},
                                 '0, '0, '0, '0};
        test_table("mul", 4, ops, as, bs, ex, 1'b0);
    endtask

    task automatic test_backpressure();
        logic acc;
        int   lat, bc;
        res_t got, exp;
        logic stable;
        exp_q.push_back(model(ALU_ADD, 8'd5, 8'd6));
        run_one(ALU_ADD, 8'd5, 8'd6, acc, lat, bc, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got.c !== 8'd11) begin
            errors++;
            $display("FAIL bp_result: got %h, required %h", got, exp);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid    = 1'b1;
            ALU_control = ALU_SUB;
            A           = 8'd1;
            B           = 8'd2;
            @(posedge clk);
            #1;
            if (sample_out() !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: out=%h valid=%b ready=%b, required %h 1 0",
                     sample_out(), out_valid, in_ready, exp);
        end
        consume();
        stable = 1'b1;
        repeat (3) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_ignored: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops[8];
        logic [W-1:0] as[8];
        logic [W-1:0] bs[8];
        res_t         ex[8] = '{default: '0};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                ops[i] = 3'($urandom);
                as[i]  = W'($urandom);
                bs[i]  = W'($urandom);
            end
            test_table("b2b", 8, ops, as, bs, ex, 1'b1);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic acc;
        logic quiet;
        int   lat, bc;
        res_t got, exp;
        send(ALU_MUL, 8'hFF, 8'hFF, acc);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({out_valid, busy, in_ready, sample_out()} !== {1'b0, 1'b0, 1'b1, 20'h0}) begin
            errors++;
            $display("FAIL midmul_reset: got valid=%b busy=%b ready=%b out=%h, required 0 0 1 00000",
                     out_valid, busy, in_ready, sample_out());
        end
        quiet = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL midmul_discard: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        exp_q.push_back(model(ALU_MUL, 8'd12, 8'd13));
        run_one(ALU_MUL, 8'd12, 8'd13, acc, lat, bc, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || lat != W) begin
            errors++;
            $display("FAIL midmul_next: got %h lat %0d, required %h lat %0d", got, lat, exp, W);
        end
        consume();
    endtask

    task automatic test_reset_priority();
        logic acc;
        int   lat, bc;
        res_t got;
        run_one(ALU_ADD, 8'd5, 8'd6, acc, lat, bc, got);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, sample_out()} !== {1'b0, 1'b1, 20'h0}) begin
            errors++;
            $display("FAIL reset_priority: valid=%b ready=%b out=%h, required 0 1 00000",
                     out_valid, in_ready, sample_out());
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
